// File: rtl/add_seq_pkg.sv
// Shared types for the limb-serial adder sequencer: FSM encoding and counter sizing.
package add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Limb counter width for a given limb count; at least one bit.
  function automatic int unsigned cnt_width(input int unsigned nlimbs);
    return (nlimbs < 2) ? 1 : $clog2(nlimbs);
  endfunction

  localparam int unsigned NLIMBS_DEF = 4;
  localparam int unsigned CNTW_DEF   = cnt_width(NLIMBS_DEF);

endpackage

// File: rtl/add_seq_ctrl_add.sv
// Narrow ripple-carry adder cell "add"; operands are WIREWIDTH+1 bits wide.
module add #(
  parameter int WIREWIDTH = 7
) (
  input  logic [WIREWIDTH:0] op1,
  input  logic [WIREWIDTH:0] op2,
  input  logic               ci,
  output logic [WIREWIDTH:0] res,
  output logic               co
);

  logic carry;

  always_comb begin
    carry = ci;
    res   = '0;
    for (int unsigned i = 0; i < WIREWIDTH + 1; i++) begin
      res[i] = op1[i] ^ op2[i] ^ carry;
      carry  = (op1[i] & op2[i]) | (carry & (op1[i] ^ op2[i]));
    end
    co = carry;
  end

endmodule

// File: rtl/add_seq_ctrl.sv
// Wide adder built by sequencing one narrow adder cell over NLIMBS limbs, LSB limb first.
// Optional subtract mode (sub port) is enabled by defining ADD_SEQ_CTRL_SUB_EN.
module add_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter int LIMBW  = 8,
  parameter int NLIMBS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    ready,
  input  logic [LIMBW*NLIMBS-1:0] op1,
  input  logic [LIMBW*NLIMBS-1:0] op2,
  input  logic                    ci,
`ifdef ADD_SEQ_CTRL_SUB_EN
  input  logic                    sub,
`endif
  output logic [LIMBW*NLIMBS-1:0] res,
  output logic                    co,
  output logic                    done
);

  localparam int unsigned W    = LIMBW * NLIMBS;
  localparam int unsigned CNTW = cnt_width(NLIMBS);
  localparam logic [CNTW-1:0] LAST = CNTW'(NLIMBS - 1);

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt;
  logic            carry_q;
  logic [W-1:0]    op1_q, op2_q;
  logic [LIMBW-1:0] cell_a, cell_b, cell_res;
  logic            cell_co;
  logic [W-1:0]    op2_cap;
  logic            ci_cap;

`ifdef ADD_SEQ_CTRL_SUB_EN
  // Two's-complement subtract: invert op2 and force carry-in to 1.
  assign op2_cap = sub ? ~op2 : op2;
  assign ci_cap  = sub ? 1'b1 : ci;
`else
  assign op2_cap = op2;
  assign ci_cap  = ci;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start) state_d = RUN;
      end
      RUN:  if (cnt == LAST) state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cell_a = '0;
    cell_b = '0;
    for (int unsigned i = 0; i < NLIMBS; i++) begin
      if (cnt == i[CNTW-1:0]) begin
        cell_a = op1_q[i*LIMBW +: LIMBW];
        cell_b = op2_q[i*LIMBW +: LIMBW];
      end
    end
  end

  add #(.WIREWIDTH(LIMBW - 1)) u_add (
    .op1 (cell_a),
    .op2 (cell_b),
    .ci  (carry_q),
    .res (cell_res),
    .co  (cell_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      carry_q <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      res     <= '0;
      co      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          op1_q   <= op1;
          op2_q   <= op2_cap;
          carry_q <= ci_cap;
          cnt     <= '0;
        end
        RUN: begin
          for (int unsigned i = 0; i < NLIMBS; i++) begin
            if (cnt == i[CNTW-1:0]) res[i*LIMBW +: LIMBW] <= cell_res;
          end
          carry_q <= cell_co;
          if (cnt == LAST) co  <= cell_co;
          else             cnt <= cnt + CNTW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
